// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin arbiter sharing one FIFO write port among NUM_REQ
//            producers; optional burst lock enabled by FIFO_ARB_BURST_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_din,
    output logic [15:0]               wr_count,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [PTR_W-1:0]   w_winner;
    logic [PTR_W-1:0]   w_sel;
    logic               w_found;
    logic               w_accept;
    logic [NUM_REQ-1:0] w_gnt;
    logic [DATA_W-1:0]  w_din;
    logic [15:0]        r_wr_count;

`ifdef FIFO_ARB_BURST_EN
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN + 1) : 1;

    logic [PTR_W-1:0]  r_owner;
    logic [PTR_W-1:0]  w_owner_nxt;
    logic [BEAT_W-1:0] r_beat;
    logic [BEAT_W-1:0] w_beat_nxt;
`endif

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        f_inc = (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // First set request bit scanning from r_ptr upward, wrapping.
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && req[idx]) begin
                w_found  = 1'b1;
                w_winner = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        w_gnt    = '0;
        w_din    = '0;
        w_sel    = w_winner;
        w_accept = w_found & ~fifo_full;
`ifdef FIFO_ARB_BURST_EN
        if (r_state == ST_LOCK) begin
            w_sel    = r_owner;
            w_accept = req[r_owner] & ~fifo_full;
        end
`endif
        if (rst) begin
            w_accept = 1'b0;
        end
        if (w_accept) begin
            w_gnt[w_sel] = 1'b1;
            w_din        = req_data[int'(w_sel)*DATA_W +: DATA_W];
        end
    end

    // Next-state logic; a stalled (full) cycle leaves every field untouched.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
`ifdef FIFO_ARB_BURST_EN
        w_owner_nxt = r_owner;
        w_beat_nxt  = r_beat;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (BURST_LEN > 1) begin
                        w_state_nxt = ST_LOCK;
                        w_owner_nxt = w_sel;
                        w_beat_nxt  = BEAT_W'(1);
                    end else begin
                        w_ptr_nxt = f_inc(w_sel);
                    end
                end
            end
            ST_LOCK: begin
                if (!req[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = f_inc(r_owner);
                    w_beat_nxt  = '0;
                end else if (w_accept) begin
                    if (r_beat == BEAT_W'(BURST_LEN - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_ptr_nxt   = f_inc(r_owner);
                        w_beat_nxt  = '0;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
`else
        w_state_nxt = ST_IDLE;
        if (w_accept) begin
            w_ptr_nxt = f_inc(w_sel);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_wr_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_accept) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= '0;
            r_beat  <= '0;
        end else begin
            r_owner <= w_owner_nxt;
            r_beat  <= w_beat_nxt;
        end
    end
`endif

    assign gnt      = w_gnt;
    assign fifo_wr  = w_accept;
    assign fifo_din = w_din;
    assign wr_count = r_wr_count;
    assign busy     = (r_state == ST_LOCK);

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Directed self-checking bench for fifo_wr_arbiter (both builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      fifo_full = 1'b0;
    logic                      fifo_wr;
    logic [DATA_W-1:0]         fifo_din;
    logic [15:0]               wr_count;
    logic                      busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .wr_count  (wr_count),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dat(input int i);
        return 32'hA5A5_0000 + 32'(i) * 32'h0000_1111;
    endfunction

    // Move to just after the next falling edge (one posedge has passed).
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_gnt(input string tag, input logic [3:0] eg);
        int idx;
        idx = 0;
        #1;
        chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
        chk({tag, "_wr"}, 32'(fifo_wr), 32'(|eg));
        if (eg != 4'b0000) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (eg[i]) idx = i;
            end
            chk({tag, "_din"}, fifo_din, dat(idx));
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = dat(i);
        end

        // Reset with all requests pending: outputs forced low.
        rst = 1'b1;
        req = 4'b1111;
        cyc();
        expect_gnt("rst_a", 4'b0000);
        cyc();
        expect_gnt("rst_b", 4'b0000);
        chk("rst_din", fifo_din, 32'h0);
        chk("rst_cnt", 32'(wr_count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        expect_gnt("first", 4'b0001);

`ifndef FIFO_ARB_BURST_EN
        // Full rotation with everyone requesting.
        cyc(); expect_gnt("rr1", 4'b0010);
        cyc(); expect_gnt("rr2", 4'b0100);
        cyc(); expect_gnt("rr3", 4'b1000);
        cyc(); expect_gnt("rr4", 4'b0001);
        cyc();
        chk("rr_cnt", 32'(wr_count), 32'd5);
        chk("nb_busy", 32'(busy), 32'h0);

        // Sparse requesters 1 and 3 alternate.
        req = 4'b1010;
        expect_gnt("sp0", 4'b0010);
        cyc(); expect_gnt("sp1", 4'b1000);
        cyc(); expect_gnt("sp2", 4'b0010);
        cyc();
        chk("sp_cnt", 32'(wr_count), 32'd8);

        // Full arriving with the request: stall without loss or duplicate.
        req       = 4'b0001;
        fifo_full = 1'b1;
        expect_gnt("full0", 4'b0000);
        cyc(); expect_gnt("full1", 4'b0000);
        cyc(); expect_gnt("full2", 4'b0000);
        chk("full_cnt", 32'(wr_count), 32'd8);
        cyc();
        fifo_full = 1'b0;
        expect_gnt("unfull", 4'b0001);
        cyc();
        req = 4'b0000;
        chk("unfull_cnt", 32'(wr_count), 32'd9);
        expect_gnt("noreq", 4'b0000);

        // Lone requester granted every cycle; then pointer wraps 3 -> 0.
        req = 4'b0100;
        expect_gnt("lone0", 4'b0100);
        cyc(); expect_gnt("lone1", 4'b0100);
        cyc();
        req = 4'b1001;
        chk("lone_cnt", 32'(wr_count), 32'd11);
        expect_gnt("wrap0", 4'b1000);
        cyc(); expect_gnt("wrap1", 4'b0001);
        cyc();
        chk("wrap_cnt", 32'(wr_count), 32'd13);
`else
        // Bursts of BURST_LEN beats per owner.
        req = 4'b0011;
        cyc(); chk("b0_busy1", 32'(busy), 32'h1); expect_gnt("b0_2", 4'b0001);
        cyc(); chk("b0_busy2", 32'(busy), 32'h1); expect_gnt("b0_3", 4'b0001);
        cyc(); chk("b0_busy3", 32'(busy), 32'h1); expect_gnt("b0_4", 4'b0001);
        cyc(); chk("b1_busy0", 32'(busy), 32'h0); expect_gnt("b1_1", 4'b0010);
        cyc(); chk("b1_busy1", 32'(busy), 32'h1); expect_gnt("b1_2", 4'b0010);
        cyc(); expect_gnt("b1_3", 4'b0010);
        cyc(); expect_gnt("b1_4", 4'b0010);
        cyc();
        chk("b_cnt", 32'(wr_count), 32'd8);
        chk("b_idle", 32'(busy), 32'h0);

        // Owner full-stall holds the lock without consuming a beat.
        expect_gnt("b2_1", 4'b0001);
        cyc();
        fifo_full = 1'b1;
        expect_gnt("b2_full", 4'b0000);
        cyc();
        chk("b2_full_busy", 32'(busy), 32'h1);
        fifo_full = 1'b0;
        expect_gnt("b2_2", 4'b0001);

        // Owner drops after two beats: lock released, requester 1 next.
        cyc();
        req = 4'b0010;
        expect_gnt("drop", 4'b0000);
        chk("drop_busy", 32'(busy), 32'h1);
        cyc();
        chk("drop_rel", 32'(busy), 32'h0);
        expect_gnt("drop_next", 4'b0010);
        cyc();
        chk("drop_cnt", 32'(wr_count), 32'd11);
`endif

        // Reset in the middle of a grant stream (beat 2).
        rst = 1'b1;
        req = 4'b0000;
        cyc();
        rst = 1'b0;
        req = 4'b0011;
        expect_gnt("mid_1", 4'b0001);
        cyc();
`ifdef FIFO_ARB_BURST_EN
        expect_gnt("mid_2", 4'b0001);
`else
        expect_gnt("mid_2", 4'b0010);
`endif
        rst = 1'b1;
        expect_gnt("mid_rst", 4'b0000);
        cyc();
        rst = 1'b0;
        chk("mid_busy", 32'(busy), 32'h0);
        chk("mid_cnt", 32'(wr_count), 32'h0);
        expect_gnt("mid_after", 4'b0001);

        // Write counter wrap 0xFFFF -> 0.
        req = 4'b0001;
        repeat (65535) cyc();
        chk("cnt_max", 32'(wr_count), 32'h0000_FFFF);
        cyc();
        chk("cnt_wrap", 32'(wr_count), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
